// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART host-command framer: FSM encodings, error codes,
// command types and the length-acceptance helper.
package uart_cmd_pkg;

  localparam logic [7:0] DEFAULT_HEAD = 8'h55;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_TYPE = 3'd1;
  localparam state_t ST_LEN  = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] CMD_SET_CHANNEL = 8'h01;
  localparam logic [7:0] CMD_READ_ADC    = 8'h05;

  // A frame must carry at least one and at most max_len payload bytes.
  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags expiry
// in the cycle the count sits at its last value with no byte arriving.
module uart_cmd_timeout #(
  parameter int P_TIMEOUT = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int W = $clog2(P_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(P_TIMEOUT - 1);

  logic [W-1:0] count;

  // An arriving byte always beats expiry, so clear masks the pulse.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames HEAD/TYPE/LENGTH/DATA host commands from the UART receive stream and
// emits one command pulse per good frame or one error pulse per aborted frame.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] P_HEAD    = DEFAULT_HEAD,
  parameter int         P_MAX_LEN = 4,
  parameter int         P_TIMEOUT = 50_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_cmd_valid,
  output logic [7:0]             o_cmd_type,
  output logic [3:0]             o_cmd_len,
  output logic [8*P_MAX_LEN-1:0] o_cmd_data,
  output logic                   o_cmd_err,
  output logic [1:0]             o_err_code,
  output logic                   o_busy
);

  state_t                 state;
  logic [7:0]             type_r;
  logic [3:0]             len_r;
  logic [3:0]             idx;
  logic [8*P_MAX_LEN-1:0] collect;
  logic [8*P_MAX_LEN-1:0] collect_next;
  logic                   head_seen;
  logic                   tmo_enable;
  logic                   tmo_expire;

  assign head_seen  = i_rx_valid && (i_rx_data == P_HEAD);
  assign tmo_enable = (state == ST_TYPE) || (state == ST_LEN) || (state == ST_DATA);
  assign o_busy     = (state != ST_IDLE);

  uart_cmd_timeout #(.P_TIMEOUT(P_TIMEOUT)) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (tmo_enable),
    .clear  (i_rx_valid),
    .expire (tmo_expire)
  );

  // Payload with the current byte merged in, so the final byte reaches the
  // output registers in the same edge that closes the frame.
  always_comb begin
    collect_next = collect;
    for (int k = 0; k < P_MAX_LEN; k++) begin
      if (idx == 4'(k)) collect_next[8*k +: 8] = i_rx_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      type_r      <= '0;
      len_r       <= '0;
      idx         <= '0;
      collect     <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_type  <= '0;
      o_cmd_len   <= '0;
      o_cmd_data  <= '0;
      o_cmd_err   <= 1'b0;
      o_err_code  <= ERR_NONE;
    end else begin
      o_cmd_valid <= 1'b0;
      o_cmd_err   <= 1'b0;
      if (tmo_expire) begin
        o_cmd_err  <= 1'b1;
        o_err_code <= ERR_TIMEOUT;
        state      <= ST_IDLE;
      end else begin
        case (state)
          // DONE shares IDLE's head check so back-to-back frames are not lost.
          ST_IDLE, ST_DONE: state <= head_seen ? ST_TYPE : ST_IDLE;
          ST_TYPE: begin
            if (i_rx_valid) begin
              type_r <= i_rx_data;
              state  <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_rx_valid) begin
              if (len_ok(i_rx_data, P_MAX_LEN)) begin
                len_r   <= i_rx_data[3:0];
                idx     <= '0;
                collect <= '0;
                state   <= ST_DATA;
              end else begin
                o_cmd_err  <= 1'b1;
                o_err_code <= ERR_LEN;
                state      <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (i_rx_valid) begin
              collect <= collect_next;
              if (idx == len_r - 4'd1) begin
                o_cmd_valid <= 1'b1;
                o_cmd_type  <= type_r;
                o_cmd_len   <= len_r;
                o_cmd_data  <= collect_next;
                state       <= ST_DONE;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed scoreboard bench for uart_cmd_parser: expected pulses are queued as
// bytes are driven and checked, including their cycle, when the DUT emits them.
module tb_uart_cmd_parser;

  localparam int P_MAX_LEN = 4;
  localparam int P_TIMEOUT = 100;

  typedef struct {
    logic        is_err;
    logic [7:0]  typ;
    logic [3:0]  len;
    logic [31:0] data;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic [7:0]  cmd_type;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        busy;

  exp_t sb[$];
  int   cyc = 0;
  int   assert_count = 0;
  int   fail_count = 0;

  uart_cmd_parser #(
    .P_HEAD    (8'h55),
    .P_MAX_LEN (P_MAX_LEN),
    .P_TIMEOUT (P_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_cmd_valid (cmd_valid),
    .o_cmd_type  (cmd_type),
    .o_cmd_len   (cmd_len),
    .o_cmd_data  (cmd_data),
    .o_cmd_err   (cmd_err),
    .o_err_code  (err_code),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t mk_cmd(input logic [7:0] typ, input logic [3:0] len,
                                  input logic [31:0] data);
    exp_t e;
    e.is_err = 1'b0; e.typ = typ; e.len = len; e.data = data; e.code = 2'd0; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.typ = 8'h00; e.len = 4'd0; e.data = 32'h0; e.code = code; e.cyc = 0;
    return e;
  endfunction

  // Drives n bytes (first byte in the most significant used position) on
  // consecutive cycles, leaving the last one strobed. When has_exp is set, the
  // expectation is queued as byte trig_idx is driven, due offset cycles after
  // the edge that samples it.
  task automatic applyStimulus(input logic [63:0] bytes, input int n, input logic has_exp,
                               input exp_t e, input int trig_idx, input int offset);
    exp_t q;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = bytes[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      if (has_exp && i == trig_idx) begin
        q = e;
        q.cyc = cyc + 1 + offset;
        sb.push_back(q);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (cmd_valid || cmd_err)) begin
      checkOutput("valid_err_exclusive", 64'(cmd_valid & cmd_err), 64'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 64'({cmd_valid, cmd_err}), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_kind", 64'({cmd_valid, cmd_err}), 64'({!e.is_err, e.is_err}));
        checkOutput("pulse_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_err) begin
          checkOutput("err_code", 64'(err_code), 64'(e.code));
        end else begin
          checkOutput("cmd_type", 64'(cmd_type), 64'(e.typ));
          checkOutput("cmd_len", 64'(cmd_len), 64'(e.len));
          checkOutput("cmd_data", 64'(cmd_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    exp_t none;
    none = mk_err(2'd0);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_err", 64'(cmd_err), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_data", 64'(cmd_data), 64'd0);
    checkOutput("reset_code", 64'(err_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single-byte command");
    applyStimulus({8'h55, 8'h01, 8'h01, 8'h08}, 4, 1'b1, mk_cmd(8'h01, 4'd1, 32'h08), 3, 0);
    idle(2);
    wait_drain(20);

    $display("[TB] leading garbage");
    applyStimulus({8'hAA, 8'h13, 8'h55, 8'h05, 8'h01, 8'h01}, 6, 1'b1,
                  mk_cmd(8'h05, 4'd1, 32'h01), 5, 0);
    idle(2);
    wait_drain(20);

    $display("[TB] bad lengths");
    applyStimulus({8'h55, 8'h01, 8'h00}, 3, 1'b1, mk_err(2'd1), 2, 0);
    idle(2);
    wait_drain(20);
    applyStimulus({8'h55, 8'h01, 8'h05, 8'h11, 8'h22}, 5, 1'b1, mk_err(2'd1), 2, 0);
    idle(2);
    wait_drain(20);
    checkOutput("busy_after_len_err", 64'(busy), 64'd0);
    applyStimulus({8'h55, 8'h05, 8'h01, 8'h01}, 4, 1'b1, mk_cmd(8'h05, 4'd1, 32'h01), 3, 0);
    idle(2);
    wait_drain(20);
    checkOutput("err_code_held", 64'(err_code), 64'd1);

    $display("[TB] full length then back-to-back frame");
    applyStimulus({8'h55, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44}, 7, 1'b1,
                  mk_cmd(8'h02, 4'd4, 32'h44332211), 6, 0);
    applyStimulus({8'h55, 8'h05, 8'h01, 8'h01}, 4, 1'b1, mk_cmd(8'h05, 4'd1, 32'h01), 3, 0);
    idle(2);
    wait_drain(20);

    $display("[TB] head byte inside frame");
    applyStimulus({8'h55, 8'h03, 8'h02, 8'h55, 8'h55}, 5, 1'b1,
                  mk_cmd(8'h03, 4'd2, 32'h5555), 4, 0);
    idle(2);
    wait_drain(20);

    $display("[TB] inter-byte timeout");
    applyStimulus({8'h55, 8'h01}, 2, 1'b1, mk_err(2'd2), 1, P_TIMEOUT);
    idle(2);
    #1;
    checkOutput("busy_in_frame", 64'(busy), 64'd1);
    wait_drain(P_TIMEOUT + 20);
    checkOutput("busy_after_timeout", 64'(busy), 64'd0);
    checkOutput("type_held", 64'(cmd_type), 64'h03);

    $display("[TB] reset mid-frame");
    applyStimulus({8'h55, 8'h02, 8'h03, 8'hAA}, 4, 1'b0, none, 0, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_type", 64'(cmd_type), 64'd0);
    checkOutput("midreset_len", 64'(cmd_len), 64'd0);
    checkOutput("midreset_data", 64'(cmd_data), 64'd0);
    checkOutput("midreset_code", 64'(err_code), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(P_TIMEOUT + 20);
    applyStimulus({8'h55, 8'h01, 8'h01, 8'h08}, 4, 1'b1, mk_cmd(8'h01, 4'd1, 32'h08), 3, 0);
    idle(2);
    wait_drain(20);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
